// File: rtl/recv_data.sv
// rtl/recv_data.sv - SPI mode-0 frame receiver into a word array; define RECV_CHECKSUM_EN to require a trailing checksum word
module recv_data #(
    parameter int WORD_W   = 16,
    parameter int WORD_NUM = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spi_sck,
    input  logic                       spi_cs_n,
    input  logic                       spi_mosi,
    output logic [WORD_NUM*WORD_W-1:0] data,
    output logic                       recv_done,
    output logic                       frame_err,
    output logic [7:0]                 word_cnt
);

`ifdef RECV_CHECKSUM_EN
    localparam int FRAME_LEN = WORD_NUM + 1;
`else
    localparam int FRAME_LEN = WORD_NUM;
`endif
    localparam int                BIT_W    = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [7:0]       LEN8     = 8'(FRAME_LEN);
    localparam logic [7:0]       OVF8     = 8'(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t              state, state_n;
    logic [2:0]          sck_sr, cs_sr, mosi_sr;
    logic [1:0]          warm;
    logic                armed, pend;
    logic [BIT_W-1:0]    bit_cnt;
    logic [WORD_W-2:0]   shift_q;
    logic [WORD_W-1:0]   shift_next;
    logic [WORD_W-1:0]   shadow [FRAME_LEN];
    logic                sck_rise, cs_fall, cs_rise, start, frame_ok;
`ifdef RECV_CHECKSUM_EN
    logic [WORD_W-1:0]   csum_acc;
`endif

    // Bits [1] are the synchronized values, bits [2] the history used for edge detection.
    // mosi is taken from its history copy: that is the level held while sck was still low.
    assign sck_rise   = sck_sr[1] & ~sck_sr[2];
    assign cs_rise    = cs_sr[1] & ~cs_sr[2];
    assign cs_fall    = ~cs_sr[1] & cs_sr[2] & armed;
    assign start      = (state == IDLE) & (cs_fall | pend);
    assign shift_next = {shift_q, mosi_sr[2]};

`ifdef RECV_CHECKSUM_EN
    assign frame_ok = (word_cnt == LEN8) && (bit_cnt == '0) && (csum_acc == shadow[WORD_NUM]);
`else
    assign frame_ok = (word_cnt == LEN8) && (bit_cnt == '0);
`endif

    // Synchronizers, FSM state and frame-start bookkeeping.
    // armed blocks the false cs_n fall seen when reset releases mid-frame with cs_n still low;
    // pend remembers a cs_n fall that arrives while the previous frame is still in CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sr  <= 3'b000;
            cs_sr   <= 3'b111;
            mosi_sr <= 3'b000;
            warm    <= 2'b00;
            armed   <= 1'b0;
            pend    <= 1'b0;
            state   <= IDLE;
        end else begin
            sck_sr  <= {sck_sr[1:0], spi_sck};
            cs_sr   <= {cs_sr[1:0], spi_cs_n};
            mosi_sr <= {mosi_sr[1:0], spi_mosi};
            warm    <= {warm[0], 1'b1};
            armed   <= armed | (warm[1] & cs_sr[1]);
            if (start)
                pend <= 1'b0;
            else if (state == CHECK && cs_fall)
                pend <= 1'b1;
            state   <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start)   state_n = RECV;
            RECV:    if (cs_rise) state_n = CHECK;
            CHECK:                state_n = IDLE;
            default:              state_n = IDLE;
        endcase
    end

    // Bit/word assembly into the shadow buffer; extra words only push word_cnt to the overflow mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            shift_q  <= '0;
            for (int i = 0; i < FRAME_LEN; i++) shadow[i] <= '0;
`ifdef RECV_CHECKSUM_EN
            csum_acc <= '0;
`endif
        end else if (start) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            shift_q  <= '0;
`ifdef RECV_CHECKSUM_EN
            csum_acc <= '0;
`endif
        end else if (state == RECV && sck_rise) begin
            shift_q <= shift_next[WORD_W-2:0];
            if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                if (word_cnt < LEN8) begin
                    for (int i = 0; i < FRAME_LEN; i++)
                        if (word_cnt == 8'(i)) shadow[i] <= shift_next;
`ifdef RECV_CHECKSUM_EN
                    if (word_cnt < 8'(WORD_NUM)) csum_acc <= csum_acc + shift_next;
`endif
                    word_cnt <= word_cnt + 8'd1;
                end else begin
                    word_cnt <= OVF8;
                end
            end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    // Frame verdict: commit shadow to data with recv_done, or flag frame_err and leave data alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            recv_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            recv_done <= 1'b0;
            frame_err <= 1'b0;
            if (state == CHECK) begin
                if (frame_ok) begin
                    recv_done <= 1'b1;
                    for (int i = 0; i < WORD_NUM; i++) data[i*WORD_W +: WORD_W] <= shadow[i];
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_recv_data.sv
// tb/tb_recv_data.sv - scoreboard bench for recv_data
`timescale 1ns/1ps
module tb_recv_data;
    localparam int WORD_W   = 16;
    localparam int WORD_NUM = 20;
    localparam int DW       = WORD_W * WORD_NUM;
    localparam int T        = 20;
`ifdef RECV_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif
    localparam int FL = WORD_NUM + CSUM;

    logic          clk = 1'b0;
    logic          rst_n, spi_sck, spi_cs_n, spi_mosi;
    logic [DW-1:0] data;
    logic          recv_done, frame_err;
    logic [7:0]    word_cnt;

    always #(T/2) clk = ~clk;

    recv_data #(.WORD_W(WORD_W), .WORD_NUM(WORD_NUM)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .data(data), .recv_done(recv_done), .frame_err(frame_err), .word_cnt(word_cnt)
    );

    typedef struct {
        logic          ok;
        logic [DW-1:0] d;
        logic [7:0]    cnt;
    } ev_t;

    ev_t               exp_q[$];
    ev_t               obs_q[$];
    logic [WORD_W-1:0] tx_q[$];
    logic [DW-1:0]     last_data = '0;
    logic [DW-1:0]     prev_data;
    logic              prev_rst = 1'b0;
    int                checks = 0;
    int                failures = 0;
    int                both_hi = 0;
    int                unexp_chg = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Capture every verdict pulse and watch for illegal output behaviour.
    always @(negedge clk) begin
        ev_t e;
        if (recv_done === 1'b1 && frame_err === 1'b1) both_hi++;
        if (rst_n === 1'b1 && prev_rst === 1'b1 && data !== prev_data && recv_done !== 1'b1) unexp_chg++;
        prev_data = data;
        prev_rst  = rst_n;
        if (recv_done === 1'b1 || frame_err === 1'b1) begin
            e.ok  = recv_done;
            e.d   = data;
            e.cnt = word_cnt;
            obs_q.push_back(e);
        end
    end

    function automatic void make_frame(input int n, input logic [WORD_W-1:0] base,
                                       input logic [WORD_W-1:0] step, input bit add_sum);
        logic [WORD_W-1:0] w, sum;
        tx_q.delete();
        sum = '0;
        for (int i = 0; i < n; i++) begin
            w = base + step * WORD_W'(i);
            tx_q.push_back(w);
            if (i < WORD_NUM) sum = sum + w;
        end
        if (add_sum && CSUM != 0) tx_q.push_back(sum);
    endfunction

    function automatic void expect_frame(input int extra);
        ev_t               e;
        logic [WORD_W-1:0] sum;
        int                nw;
        nw   = tx_q.size();
        e.ok = (nw == FL) && (extra == 0);
        if (e.ok && CSUM != 0) begin
            sum = '0;
            for (int i = 0; i < WORD_NUM; i++) sum = sum + tx_q[i];
            e.ok = (sum == tx_q[FL-1]);
        end
        e.cnt = (nw > FL) ? 8'(FL + 1) : 8'(nw);
        if (e.ok)
            for (int i = 0; i < WORD_NUM; i++) last_data[i*WORD_W +: WORD_W] = tx_q[i];
        e.d = last_data;
        exp_q.push_back(e);
    endfunction

    task automatic spi_bit(input logic b, input int hc);
        spi_mosi = b;
        #(hc*T) spi_sck = 1'b1;
        #(hc*T) spi_sck = 1'b0;
    endtask

    task automatic send_words(input int hc);
        logic [WORD_W-1:0] w;
        for (int k = 0; k < tx_q.size(); k++) begin
            w = tx_q[k];
            for (int b = WORD_W-1; b >= 0; b--) spi_bit(w[b], hc);
        end
    endtask

    task automatic send_frame(input int extra, input int hc, input int gap);
        spi_cs_n = 1'b0;
        #(hc*T);
        send_words(hc);
        for (int b = 0; b < extra; b++) spi_bit(b[0], hc);
        #(hc*T) spi_cs_n = 1'b1;
        #(gap*T);
    endtask

    task automatic wait_obs(input int n, input string tag);
        ev_t o, e;
        int  t;
        t = 0;
        while (obs_q.size() < n && t < 4000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #3;
        check({tag, "_events"}, DW'(obs_q.size()), DW'(n));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_done"}, DW'(o.ok), DW'(e.ok));
            check({tag, "_data"}, o.d, e.d);
            check({tag, "_cnt"}, DW'(o.cnt), DW'(e.cnt));
        end
        obs_q.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("rst_data", data, '0);
        check("rst_done", DW'(recv_done), '0);
        check("rst_err", DW'(frame_err), '0);
        check("rst_cnt", DW'(word_cnt), '0);
        rst_n = 1'b1;
        #(5*T);

        // valid frame 0x0001..0x0014 at 1 MHz sck
        make_frame(WORD_NUM, 16'h0001, 16'h0001, 1'b1);
        expect_frame(0);
        send_frame(0, 25, 10);
        wait_obs(1, "frame_a");
        check("a_word0", DW'(data[15:0]), DW'(16'h0001));
        check("a_word19", DW'(data[319:304]), DW'(16'h0014));
        check("a_cnt", DW'(word_cnt), DW'(FL));

        // short frame
        make_frame(WORD_NUM-1, 16'h0100, 16'h0001, 1'b0);
        expect_frame(0);
        send_frame(0, 5, 10);
        wait_obs(1, "short");

        // full frame plus 7 stray bits
        make_frame(WORD_NUM, 16'h0200, 16'h0001, 1'b1);
        expect_frame(7);
        send_frame(7, 5, 10);
        wait_obs(1, "partial");

        // overflow by two words
        make_frame(WORD_NUM+2, 16'h0300, 16'h0001, 1'b1);
        expect_frame(0);
        send_frame(0, 5, 10);
        wait_obs(1, "overflow");

`ifdef RECV_CHECKSUM_EN
        make_frame(WORD_NUM, 16'h0001, 16'h0001, 1'b1);
        check("csum_word", DW'(tx_q[WORD_NUM]), DW'(16'h00D2));
        tx_q[WORD_NUM] = tx_q[WORD_NUM] + 16'd1;
        expect_frame(0);
        send_frame(0, 5, 10);
        wait_obs(1, "bad_csum");
`endif

        // reset in the middle of a frame: discarded, no verdict pulse
        make_frame(10, 16'h0400, 16'h0001, 1'b0);
        spi_cs_n = 1'b0;
        #(5*T);
        send_words(5);
        rst_n = 1'b0;
        #(3*T) rst_n = 1'b1;
        #(5*T);
        check("midrst_data", data, '0);
        last_data = '0;
        spi_cs_n = 1'b1;
        #(10*T);
        check("midrst_events", DW'(obs_q.size()), '0);

        make_frame(WORD_NUM, 16'hA5A5, 16'h0000, 1'b1);
        expect_frame(0);
        send_frame(0, 5, 10);
        wait_obs(1, "a5");

        // sck toggling with cs_n high must be ignored
        repeat (16) begin
            #(5*T) spi_sck = 1'b1;
            #(5*T) spi_sck = 1'b0;
        end
        #(10*T);
        check("idle_sck_events", DW'(obs_q.size()), '0);

        // back-to-back frames with a 2-clk CS gap
        make_frame(WORD_NUM, 16'h1000, 16'h0003, 1'b1);
        expect_frame(0);
        send_frame(0, 5, 2);
        make_frame(WORD_NUM, 16'h2000, 16'h0007, 1'b1);
        expect_frame(0);
        send_frame(0, 5, 10);
        wait_obs(2, "b2b");

        check("both_high", DW'(both_hi), '0);
        check("data_changed", DW'(unexp_chg), '0);
        check("pending_exp", DW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
